// File: rtl/rf_pkg.sv
// Shared defaults for the decode-stage register file and its pending-write scoreboard.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DEPTH    = 2 ** RF_ADDR_W;
  localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for long-latency producers, a running count of pending
// registers, and per-read-port busy flags.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD-1:0]          rbusy,
  output logic [ADDR_W:0]            pend_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] r_pend;
  logic [CW-1:0]    r_cnt;
  logic [DEPTH-1:0] w_pend_nxt;
  logic             w_mark_ok;
  logic             w_clr_ok;
  logic             w_set;
  logic             w_clr;

  // A mark on the written address overrides the clear, so the count only moves on real bit flips.
  always_comb begin
    w_mark_ok  = mark_en && !((ZERO_REG != 0) && (mark_addr == ADDR_W'(RF_ZERO_IDX)));
    w_clr_ok   = we && !(w_mark_ok && (mark_addr == waddr));
    w_set      = w_mark_ok && !r_pend[mark_addr];
    w_clr      = w_clr_ok && r_pend[waddr];
    w_pend_nxt = r_pend;
    if (w_clr_ok) w_pend_nxt[waddr] = 1'b0;
    if (w_mark_ok) w_pend_nxt[mark_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= r_cnt + CW'(w_set) - CW'(w_clr);
    end
  end

  assign pend_cnt = r_cnt;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] w_ra;
    assign w_ra     = raddr[i*ADDR_W +: ADDR_W];
    assign rbusy[i] = !rst
                      && !((ZERO_REG != 0) && (w_ra == ADDR_W'(RF_ZERO_IDX)))
                      && r_pend[w_ra]
                      && !((BYPASS != 0) && we && (waddr == w_ra));
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read, single-write register file with write-through bypass, hardwired zero
// register and a pending-write scoreboard for hazard detection.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr,
  output logic [ADDR_W:0]            pend_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_ok;

  assign w_wr_ok = we && !((ZERO_REG != 0) && (waddr == ADDR_W'(RF_ZERO_IDX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Priority, lowest to highest: storage, same-cycle bypass, zero register, reset.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    assign w_ra = raddr[i*ADDR_W +: ADDR_W];
    always_comb begin
      w_rd = r_mem[w_ra];
      if ((BYPASS != 0) && we && (waddr == w_ra)) w_rd = wdata;
      if ((ZERO_REG != 0) && (w_ra == ADDR_W'(RF_ZERO_IDX))) w_rd = '0;
      if (rst) w_rd = '0;
    end
    assign rdata[i*DATA_W +: DATA_W] = w_rd;
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .mark_en  (mark_en),
    .mark_addr(mark_addr),
    .raddr    (raddr),
    .rbusy    (rbusy),
    .pend_cnt (pend_cnt)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, reset corner sequence and a randomised
// model-checked run; a BYPASS=0 instance shares the inputs for the no-forwarding case.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic [5:0]  pend_cnt;
  logic [63:0] nb_rdata;
  logic [1:0]  nb_rbusy;
  logic [5:0]  nb_pend_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [103:0] exp_q[$];

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .rbusy(rbusy), .mark_en(mark_en), .mark_addr(mark_addr),
    .pend_cnt(pend_cnt)
  );

  reg_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(nb_rdata), .rbusy(nb_rbusy), .mark_en(mark_en), .mark_addr(mark_addr),
    .pend_cnt(nb_pend_cnt)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        me;
    logic [4:0]  ma;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic [5:0]  e_cnt;
    logic [31:0] e_nb;
  } vec_t;

  vec_t vecs[15];

  // Reference model for the random phase.
  logic [31:0] m_mem [32];
  logic        m_pend[32];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic me, input logic [4:0] ma,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; mark_en = me; mark_addr = ma;
    raddr = {ra1, ra0};
  endtask

  task automatic compare_pop(input string tag);
    logic [103:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " queue_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " rd0"},    {32'd0, rdata[31:0]},    {32'd0, e[103:72]});
    check({tag, " rd1"},    {32'd0, rdata[63:32]},   {32'd0, e[71:40]});
    check({tag, " busy"},   {62'd0, rbusy},          {62'd0, e[39:38]});
    check({tag, " cnt"},    {58'd0, pend_cnt},       {58'd0, e[37:32]});
    check({tag, " nb_rd0"}, {32'd0, nb_rdata[31:0]}, {32'd0, e[31:0]});
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_pend[a] && !(we && waddr == a);
  endfunction

  function automatic logic [5:0] m_count();
    logic [5:0] c = '0;
    for (int k = 0; k < 32; k++) c += {5'd0, m_pend[k]};
    return c;
  endfunction

  initial begin
    rst = 1'b1; we = 0; waddr = 0; wdata = 0; raddr = 0; mark_en = 0; mark_addr = 0;

    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd4, 32'h0,        32'h0,        2'b00, 6'd0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd3, 5'd4, 32'h0,        32'h0,        2'b01, 6'd1, 32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 32'h0,        32'h0,        2'b11, 6'd2, 32'h0};
    vecs[5]  = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 5'd3, 5'd4, 32'h33,       32'h0,        2'b10, 6'd2, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 32'h33,       32'h0,        2'b10, 6'd1, 32'h33};
    vecs[7]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00, 6'd1, 32'h0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h99,       32'h99,       2'b11, 6'd2, 32'h99};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h99,       32'h0,        2'b01, 6'd2, 32'h99};
    vecs[10] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 6'd2, 32'h0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h99,       2'b10, 6'd2, 32'h0};
    vecs[12] = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       2'b00, 6'd2, 32'h0};
    vecs[13] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd3, 5'd4, 5'd3, 32'h44,       32'h33,       2'b00, 6'd2, 32'h0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd3, 32'h44,       32'h33,       2'b10, 6'd2, 32'h44};

    // Reset release and idle state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset rdata", rdata, 64'd0);
    check("reset rbusy", {62'd0, rbusy}, 64'd0);
    check("reset cnt",   {58'd0, pend_cnt}, 64'd0);

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back({vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_nb});
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].me, vecs[i].ma, vecs[i].ra0, vecs[i].ra1);
      #1;
      compare_pop($sformatf("vec%0d", i));
    end

    // Asynchronous reset in mid-cycle with state present.
    drive(1'b1, 5'd2, 32'h123, 1'b0, 5'd0, 5'd2, 5'd9);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd9);
    #1;
    check("pre_rst r2", {32'd0, rdata[31:0]}, 64'h123);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst r2",   {32'd0, rdata[31:0]}, 64'd0);
    check("async_rst busy", {62'd0, rbusy}, 64'd0);
    check("async_rst cnt",  {58'd0, pend_cnt}, 64'd0);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 5'd6, 5'd2);
    #1;
    check("in_rst bypass", {32'd0, rdata[31:0]}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; mark_en = 1'b0;
    #1;
    check("post_rst r6",  {32'd0, rdata[31:0]}, 64'd0);
    check("post_rst r2",  {32'd0, rdata[63:32]}, 64'd0);
    check("post_rst cnt", {58'd0, pend_cnt}, 64'd0);

    // Randomised run against the reference model (starts from reset state).
    for (int k = 0; k < 32; k++) begin
      m_mem[k] = '0;
      m_pend[k] = 1'b0;
    end
    for (int i = 0; i < 300; i++) begin
      logic        w, me, set_ok;
      logic [4:0]  wa, ma, ra0, ra1;
      logic [31:0] wd;
      w   = 1'($urandom_range(0, 1));
      me  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 7));
      ma  = 5'($urandom_range(0, 7));
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      wd  = $urandom;
      drive(w, wa, wd, me, ma, ra0, ra1);
      exp_q.push_back({m_read(ra0, 1'b1), m_read(ra1, 1'b1), m_busy(ra1), m_busy(ra0),
                       m_count(), m_read(ra0, 1'b0)});
      #1;
      compare_pop($sformatf("rand%0d", i));
      if (w && wa != 5'd0) m_mem[wa] = wd;
      set_ok = me && ma != 5'd0;
      if (w) m_pend[wa] = 1'b0;
      if (set_ok) m_pend[ma] = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
